// File: rtl/rf_sched_pkg.sv
// Shared defaults and priority-state encoding for the writeback scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rf_sched_pkg;

   localparam int NUM_REGS_DEF = 32;
   localparam int DATA_W_DEF   = 32;
   localparam int ADDR_W_DEF   = 5;

   // Which writeback requester wins when both are valid in the same cycle.
   typedef enum logic {
      PRI_ALU = 1'b0,
      PRI_LD  = 1'b1
   } pri_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter (ALU vs load) with a registered priority FSM.
// Latency: grants are combinational from requests and the current priority state.
// Backpressure: the losing requester is not granted and must hold its request.
module rr_arb2
   import rf_sched_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic req_alu,
   input  logic req_ld,
   output logic gnt_alu,
   output logic gnt_ld
);

   pri_state_t state;

   // Grant the prioritized requester on conflict; a lone requester always wins.
   // Grants are forced low while reset is held.
   always_comb begin
      gnt_alu = 1'b0;
      gnt_ld  = 1'b0;
      if (!reset) begin
         gnt_alu = req_alu && (!req_ld || (state == PRI_ALU));
         gnt_ld  = req_ld && !gnt_alu;
      end
   end

   // After a grant, favour the requester that did not win; hold when idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= PRI_ALU;
      end else if (gnt_alu) begin
         state <= PRI_LD;
      end else if (gnt_ld) begin
         state <= PRI_ALU;
      end
   end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register scoreboard with issue interlock and ALU/load writeback-port arbitration.
// Latency: stall, ready and rf_* are combinational; busy/err update at the next edge.
// Backpressure: issue stalls on any busy operand; a non-granted writeback holds until ready.
module regfile_wb_scheduler
   import rf_sched_pkg::*;
#(
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                iss_valid,
   input  logic [ADDR_W-1:0]   iss_rs1,
   input  logic [ADDR_W-1:0]   iss_rs2,
   input  logic                iss_wr,
   input  logic [ADDR_W-1:0]   iss_rd,
   output logic                iss_stall,
   input  logic                alu_valid,
   input  logic [ADDR_W-1:0]   alu_rd,
   input  logic [DATA_W-1:0]   alu_data,
   output logic                alu_ready,
   input  logic                ld_valid,
   input  logic [ADDR_W-1:0]   ld_rd,
   input  logic [DATA_W-1:0]   ld_data,
   output logic                ld_ready,
   output logic                rf_we,
   output logic [ADDR_W-1:0]   rf_addr,
   output logic [DATA_W-1:0]   rf_wdata,
   output logic [NUM_REGS-1:0] busy,
   output logic                err
);

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] set_vec;
   logic [NUM_REGS-1:0] clr_vec;
   logic [NUM_REGS-1:0] busy_nxt;
   logic                gnt_alu;
   logic                gnt_ld;
   logic                iss_accept;
   logic [ADDR_W-1:0]   wb_rd;
   logic [DATA_W-1:0]   wb_data;

   assign busy = busy_q;

   rr_arb2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .req_alu (alu_valid),
      .req_ld  (ld_valid),
      .gnt_alu (gnt_alu),
      .gnt_ld  (gnt_ld)
   );

   assign alu_ready = gnt_alu;
   assign ld_ready  = gnt_ld;

   // Steer the granted request onto the write port; everything is zero when idle.
   always_comb begin
      wb_rd   = '0;
      wb_data = '0;
      if (gnt_alu) begin
         wb_rd   = alu_rd;
         wb_data = alu_data;
      end else if (gnt_ld) begin
         wb_rd   = ld_rd;
         wb_data = ld_data;
      end
   end

   // r0 is hardwired, so a granted write to it is consumed without a write strobe.
   assign rf_we    = (gnt_alu || gnt_ld) && (wb_rd != '0);
   assign rf_addr  = wb_rd;
   assign rf_wdata = wb_data;

   // Interlock on pending writes to any operand; no bypass from the writeback port.
   assign iss_stall  = iss_valid &&
                       (busy_q[iss_rs1] || busy_q[iss_rs2] || (iss_wr && busy_q[iss_rd]));
   assign iss_accept = iss_valid && !iss_stall;

   // Per-register set/clear requests; set is applied last so a same-edge collision sets.
   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (iss_accept && iss_wr && (iss_rd != '0)) begin
         set_vec[iss_rd] = 1'b1;
      end
      if (rf_we) begin
         clr_vec[wb_rd] = 1'b1;
      end
      busy_nxt    = (busy_q & ~clr_vec) | set_vec;
      busy_nxt[0] = 1'b0;
   end

   // Scoreboard register; reset drops every pending write immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_nxt;
      end
   end

   // Sticky error for a writeback to a register with no pending write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err <= 1'b0;
      end else if (rf_we && !busy_q[wb_rd]) begin
         err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;

   logic        clk;
   logic        reset;
   logic        iss_valid;
   logic [4:0]  iss_rs1;
   logic [4:0]  iss_rs2;
   logic        iss_wr;
   logic [4:0]  iss_rd;
   logic        iss_stall;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        alu_ready;
   logic        ld_valid;
   logic [4:0]  ld_rd;
   logic [31:0] ld_data;
   logic        ld_ready;
   logic        rf_we;
   logic [4:0]  rf_addr;
   logic [31:0] rf_wdata;
   logic [31:0] busy;
   logic        err;

   int errors;
   int checks;

   regfile_wb_scheduler dut (
      .clk       (clk),
      .reset     (reset),
      .iss_valid (iss_valid),
      .iss_rs1   (iss_rs1),
      .iss_rs2   (iss_rs2),
      .iss_wr    (iss_wr),
      .iss_rd    (iss_rd),
      .iss_stall (iss_stall),
      .alu_valid (alu_valid),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .alu_ready (alu_ready),
      .ld_valid  (ld_valid),
      .ld_rd     (ld_rd),
      .ld_data   (ld_data),
      .ld_ready  (ld_ready),
      .rf_we     (rf_we),
      .rf_addr   (rf_addr),
      .rf_wdata  (rf_wdata),
      .busy      (busy),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0; iss_wr = 0; iss_rd = 0;
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      ld_valid = 0; ld_rd = 0; ld_data = 0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      idle_inputs();
      reset = 1'b1;

      // Reset state, with requests presented to prove outputs are held low.
      alu_valid = 1; ld_valid = 1; iss_valid = 1; iss_rs1 = 5'd3;
      #2;
      chk("rst_busy", busy, 32'h0);
      chk("rst_err", {31'b0, err}, 32'd0);
      chk("rst_alu_ready", {31'b0, alu_ready}, 32'd0);
      chk("rst_ld_ready", {31'b0, ld_ready}, 32'd0);
      chk("rst_rf_we", {31'b0, rf_we}, 32'd0);
      chk("rst_stall", {31'b0, iss_stall}, 32'd0);
      tick();
      idle_inputs();
      #1 reset = 1'b0;
      #1;
      chk("idle_rf_addr", {27'b0, rf_addr}, 32'd0);
      chk("idle_rf_wdata", rf_wdata, 32'd0);

      // Both requesters valid for four cycles (rd=0): ALU, LD, ALU, LD.
      tick();
      alu_valid = 1; ld_valid = 1; alu_data = 32'h11; ld_data = 32'h22;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("rr%0d_alu_ready", i), {31'b0, alu_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
         chk($sformatf("rr%0d_ld_ready", i), {31'b0, ld_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
         chk($sformatf("rr%0d_rf_we", i), {31'b0, rf_we}, 32'd0);
         tick();
      end
      idle_inputs();

      // Priority is back at ALU. Make r7 busy, then a load-only write to r7.
      iss_valid = 1; iss_wr = 1; iss_rd = 5'd7;
      #1;
      chk("iss7_stall", {31'b0, iss_stall}, 32'd0);
      tick();
      idle_inputs();
      chk("iss7_busy", busy, 32'h0000_0080);
      ld_valid = 1; ld_rd = 5'd7; ld_data = 32'h0000_0077;
      #1;
      chk("ld7_ready", {31'b0, ld_ready}, 32'd1);
      chk("ld7_alu_ready", {31'b0, alu_ready}, 32'd0);
      chk("ld7_rf_we", {31'b0, rf_we}, 32'd1);
      chk("ld7_rf_addr", {27'b0, rf_addr}, 32'd7);
      chk("ld7_rf_wdata", rf_wdata, 32'h0000_0077);
      tick();
      idle_inputs();
      chk("ld7_busy_clr", busy, 32'h0);
      chk("ld7_err", {31'b0, err}, 32'd0);
      // State should favour ALU after the load grant.
      alu_valid = 1; ld_valid = 1;
      #1;
      chk("post_ld_alu_wins", {31'b0, alu_ready}, 32'd1);
      chk("post_ld_ld_waits", {31'b0, ld_ready}, 32'd0);
      tick();
      idle_inputs();

      // RAW interlock on r5 released by ALU writeback of 0xDEADBEEF.
      iss_valid = 1; iss_wr = 1; iss_rd = 5'd5;
      tick();
      iss_wr = 0; iss_rd = 0; iss_rs1 = 5'd5;
      #1;
      chk("raw_busy5", busy, 32'h0000_0020);
      chk("raw_stall_a", {31'b0, iss_stall}, 32'd1);
      tick();
      chk("raw_stall_b", {31'b0, iss_stall}, 32'd1);
      alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
      #1;
      chk("raw_wb_ready", {31'b0, alu_ready}, 32'd1);
      chk("raw_wb_we", {31'b0, rf_we}, 32'd1);
      chk("raw_wb_addr", {27'b0, rf_addr}, 32'd5);
      chk("raw_wb_data", rf_wdata, 32'hDEAD_BEEF);
      chk("raw_stall_wb_cycle", {31'b0, iss_stall}, 32'd1);
      tick();
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      #1;
      chk("raw_stall_released", {31'b0, iss_stall}, 32'd0);
      chk("raw_busy_clear", busy, 32'h0);
      chk("raw_err", {31'b0, err}, 32'd0);
      tick();
      idle_inputs();

      // ALU write to r0: consumed, no write strobe, no state change.
      alu_valid = 1; alu_rd = 5'd0; alu_data = 32'h1;
      #1;
      chk("r0_ready", {31'b0, alu_ready}, 32'd1);
      chk("r0_rf_we", {31'b0, rf_we}, 32'd0);
      tick();
      idle_inputs();
      chk("r0_busy", busy, 32'h0);
      chk("r0_err", {31'b0, err}, 32'd0);

      // Unexpected write to r9 (not busy): performed, err sticky.
      alu_valid = 1; alu_rd = 5'd9; alu_data = 32'h0000_0999;
      #1;
      chk("r9_rf_we", {31'b0, rf_we}, 32'd1);
      chk("r9_rf_addr", {27'b0, rf_addr}, 32'd9);
      chk("r9_err_before", {31'b0, err}, 32'd0);
      tick();
      idle_inputs();
      chk("r9_err_set", {31'b0, err}, 32'd1);
      tick();
      chk("r9_err_sticky", {31'b0, err}, 32'd1);

      // Same-edge set (issue rd=9) and clear (ALU rd=9) resolves to set.
      iss_valid = 1; iss_wr = 1; iss_rd = 5'd9;
      alu_valid = 1; alu_rd = 5'd9; alu_data = 32'h9;
      tick();
      idle_inputs();
      chk("collide_busy9", busy, 32'h0000_0200);
      // Destination-busy interlock and iss_valid gating.
      iss_wr = 1; iss_rd = 5'd9;
      #1;
      chk("rd_busy_no_valid", {31'b0, iss_stall}, 32'd0);
      iss_valid = 1;
      #1;
      chk("rd_busy_stall", {31'b0, iss_stall}, 32'd1);
      iss_wr = 0;
      #1;
      chk("rd_busy_no_wr", {31'b0, iss_stall}, 32'd0);
      idle_inputs();

      // Set r3 and r12, then reset between edges (priority currently favours LD).
      iss_valid = 1; iss_wr = 1; iss_rd = 5'd3;
      tick();
      iss_rd = 5'd12;
      tick();
      idle_inputs();
      chk("pre_rst_busy", busy, 32'h0000_1208);
      alu_valid = 1; ld_valid = 1; iss_valid = 1; iss_rs1 = 5'd3;
      #2 reset = 1'b1;
      #1;
      chk("midrst_busy", busy, 32'h0);
      chk("midrst_err", {31'b0, err}, 32'd0);
      chk("midrst_alu_ready", {31'b0, alu_ready}, 32'd0);
      chk("midrst_ld_ready", {31'b0, ld_ready}, 32'd0);
      chk("midrst_stall", {31'b0, iss_stall}, 32'd0);
      tick();
      reset = 1'b0;
      #1;
      chk("postrst_alu_first", {31'b0, alu_ready}, 32'd1);
      chk("postrst_ld_waits", {31'b0, ld_ready}, 32'd0);
      tick();
      idle_inputs();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard time limit so the run always terminates.
   initial begin
      #50000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
